// File: rtl/pedo_weight_regfile.sv
// Double-buffered weight register file and step accumulator for the pedometer classifier.
// Optional macro STEP_SAT_EN: saturate total_steps at all-ones instead of wrapping.
module pedo_weight_regfile #(
   parameter int DATA_W    = 8,
   parameter int NUM_REGS  = 8,
   parameter int ADDR_W    = 3,
   parameter int STEP_W    = 16,
   parameter int RESET_VAL = 10
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       we1,
   input  logic [ADDR_W-1:0]          addr1,
   input  logic [DATA_W-1:0]          data1,
   input  logic                       we2,
   input  logic [ADDR_W-1:0]          addr2,
   input  logic [DATA_W-1:0]          data2,
   input  logic                       commit,
   input  logic [ADDR_W-1:0]          rd_addr,
   output logic [DATA_W-1:0]          rd_data,
   output logic [NUM_REGS*DATA_W-1:0] weights,
   output logic                       pending,
   input  logic                       step_inc,
   input  logic                       step_clr,
   output logic [STEP_W-1:0]          total_steps,
   output logic                       step_ovf
);

   localparam logic [DATA_W-1:0] RV       = DATA_W'(RESET_VAL);
   localparam logic [STEP_W-1:0] STEP_MAX = '1;

   logic [DATA_W-1:0] shadow_q [NUM_REGS];
   logic [DATA_W-1:0] shadow_d [NUM_REGS];
   logic [DATA_W-1:0] active_q [NUM_REGS];
   logic [DATA_W-1:0] active_d [NUM_REGS];
   logic [DATA_W-1:0] rd_q, rd_d;
   logic              pend_q, pend_d;
   logic [STEP_W-1:0] steps_q, steps_d;
   logic              ovf_q, ovf_d;
   logic              wr_any;

   // Out-of-range addresses match no register, so they write and read nothing.
   always_comb begin
      shadow_d = shadow_q;
      rd_d     = '0;
      wr_any   = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (we1 && addr1 == ADDR_W'(i)) begin
            shadow_d[i] = data1;
            wr_any      = 1'b1;
         end
         if (we2 && addr2 == ADDR_W'(i)) begin
            shadow_d[i] = data2;
            wr_any      = 1'b1;
         end
         if (rd_addr == ADDR_W'(i)) begin
            rd_d = shadow_q[i];
         end
      end
      active_d = commit ? shadow_d : active_q;
      if (commit) begin
         pend_d = 1'b0;
      end else begin
         pend_d = pend_q | wr_any;
      end
   end

   always_comb begin
      steps_d = steps_q;
      ovf_d   = ovf_q;
      if (step_clr) begin
         steps_d = '0;
         ovf_d   = 1'b0;
      end else if (step_inc) begin
         if (steps_q == STEP_MAX) begin
            ovf_d = 1'b1;
`ifdef STEP_SAT_EN
            steps_d = STEP_MAX;
`else
            steps_d = '0;
`endif
         end else begin
            steps_d = steps_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            shadow_q[i] <= RV;
            active_q[i] <= RV;
         end
         rd_q    <= '0;
         pend_q  <= 1'b0;
         steps_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         rd_q     <= rd_d;
         pend_q   <= pend_d;
         steps_q  <= steps_d;
         ovf_q    <= ovf_d;
      end
   end

   always_comb begin
      weights = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         weights[i*DATA_W +: DATA_W] = active_q[i];
      end
   end

   assign rd_data     = rd_q;
   assign pending     = pend_q;
   assign total_steps = steps_q;
   assign step_ovf    = ovf_q;

endmodule

// File: tb/tb_pedo_weight_regfile.sv
// Scoreboard bench for pedo_weight_regfile: stimulus pushes model expectations,
// a monitor pops and compares one entry per clock edge.
module tb_pedo_weight_regfile;

   localparam int DW = 8;
   localparam int NR = 8;
   localparam int AW = 4;
   localparam int SW = 4;
   localparam int RV = 10;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          we1 = 1'b0, we2 = 1'b0, commit = 1'b0;
   logic [AW-1:0] addr1 = '0, addr2 = '0, rd_addr = '0;
   logic [DW-1:0] data1 = '0, data2 = '0;
   logic          step_inc = 1'b0, step_clr = 1'b0;
   logic [DW-1:0] rd_data;
   logic [NR*DW-1:0] weights;
   logic          pending;
   logic [SW-1:0] total_steps;
   logic          step_ovf;

   pedo_weight_regfile #(
      .DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .STEP_W(SW), .RESET_VAL(RV)
   ) dut (
      .clk(clk), .reset(reset),
      .we1(we1), .addr1(addr1), .data1(data1),
      .we2(we2), .addr2(addr2), .data2(data2),
      .commit(commit), .rd_addr(rd_addr), .rd_data(rd_data),
      .weights(weights), .pending(pending),
      .step_inc(step_inc), .step_clr(step_clr),
      .total_steps(total_steps), .step_ovf(step_ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0]    rd;
      logic [NR*DW-1:0] w;
      logic             pend;
      logic [SW-1:0]    steps;
      logic             ovf;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state
   int m_sh [NR];
   int m_ac [NR];
   int m_rd, m_pend, m_steps, m_ovf;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < NR; i++) begin
         m_sh[i] = RV;
         m_ac[i] = RV;
      end
      m_rd = 0; m_pend = 0; m_steps = 0; m_ovf = 0;
   endfunction

   function automatic exp_t model_snap();
      exp_t e;
      e.rd = DW'(m_rd);
      e.w = '0;
      for (int i = 0; i < NR; i++) e.w[i*DW +: DW] = DW'(m_ac[i]);
      e.pend = (m_pend != 0);
      e.steps = SW'(m_steps);
      e.ovf = (m_ovf != 0);
      return e;
   endfunction

   task automatic check_reset_vals(input string tag);
      exp_t e;
      e.rd = '0; e.pend = 1'b0; e.steps = '0; e.ovf = 1'b0;
      for (int i = 0; i < NR; i++) e.w[i*DW +: DW] = DW'(RV);
      chk({tag, "_rd"}, 64'(rd_data), 64'(e.rd));
      chk({tag, "_weights"}, 64'(weights), 64'(e.w));
      chk({tag, "_pending"}, 64'(pending), 64'(e.pend));
      chk({tag, "_steps"}, 64'(total_steps), 64'(e.steps));
      chk({tag, "_ovf"}, 64'(step_ovf), 64'(e.ovf));
   endtask

   task automatic drive(input logic w1, input int a1, input int d1,
                        input logic w2, input int a2, input int d2,
                        input logic c, input int ra, input logic si, input logic sc);
      int max_steps;
      bit wrote;
      @(negedge clk);
      we1 = w1; addr1 = AW'(a1); data1 = DW'(d1);
      we2 = w2; addr2 = AW'(a2); data2 = DW'(d2);
      commit = c; rd_addr = AW'(ra); step_inc = si; step_clr = sc;
      max_steps = (1 << SW) - 1;
      m_rd = (ra < NR) ? m_sh[ra] : 0;
      wrote = 0;
      if (w1 && a1 < NR) begin m_sh[a1] = d1 & 8'hff; wrote = 1; end
      if (w2 && a2 < NR) begin m_sh[a2] = d2 & 8'hff; wrote = 1; end
      if (c) begin
         m_ac = m_sh;
         m_pend = 0;
      end else if (wrote) begin
         m_pend = 1;
      end
      if (sc) begin
         m_steps = 0; m_ovf = 0;
      end else if (si) begin
         if (m_steps == max_steps) m_ovf = 1;
`ifdef STEP_SAT_EN
         m_steps = (m_steps + 1 > max_steps) ? max_steps : m_steps + 1;
`else
         m_steps = (m_steps + 1) % (max_steps + 1);
`endif
      end
      q.push_back(model_snap());
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("rd_data", 64'(rd_data), 64'(e.rd));
            chk("weights", 64'(weights), 64'(e.w));
            chk("pending", 64'(pending), 64'(e.pend));
            chk("total_steps", 64'(total_steps), 64'(e.steps));
            chk("step_ovf", 64'(step_ovf), 64'(e.ovf));
         end
      end
   end

   initial begin : stim
      model_reset();
      #1 reset = 1'b1;
      #1 check_reset_vals("por");
      @(negedge clk);
      reset = 1'b0;

      // Shadow write, readback, then commit
      drive(1, 2, 'h55, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 2, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 1, 2, 0, 0);
      idle();
      // Dual write same address with commit: port 2 wins, pending stays 0
      drive(1, 4, 'h11, 1, 4, 'h22, 1, 4, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 4, 0, 0);
      // Out-of-range writes and read
      drive(1, 9, 'h77, 1, 12, 'h66, 0, 9, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 9, 0, 0);
      // Step accumulator to all-ones, overflow, then clear
      for (int i = 0; i < 15; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      idle();

      for (int n = 0; n < 400; n++) begin
         drive($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 255),
               $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 255),
               ($urandom_range(0, 3) == 0), $urandom_range(0, 15),
               $urandom_range(0, 1), ($urandom_range(0, 15) == 0));
      end

      // Asynchronous reset mid-cycle with a write and commit in flight
      drive(1, 3, 'h99, 0, 0, 0, 0, 3, 1, 0);
      @(posedge clk);
      #3;
      we1 = 1'b1; addr1 = 4'd1; data1 = 8'hAA; commit = 1'b1; step_inc = 1'b1;
      reset = 1'b1;
      #1 check_reset_vals("async");
      @(posedge clk);
      #1 check_reset_vals("held");
      @(negedge clk);
      reset = 1'b0;
      we1 = 1'b0; commit = 1'b0; step_inc = 1'b0;
      model_reset();

      for (int n = 0; n < 60; n++) begin
         drive($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 255),
               $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 255),
               ($urandom_range(0, 3) == 0), $urandom_range(0, 15),
               $urandom_range(0, 1), ($urandom_range(0, 15) == 0));
      end

      repeat (3) @(posedge clk);
      #2;
      chk("scoreboard_drained", 64'(q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
